serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 97 +++++++++
 tb/tb_serial_sub.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents diff/borrow/zero with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one bit processed per edge, LSB first
// DONE  | result loaded; done pulse for one cycle
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             br;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // New bit enters at the MSB of res; after WIDTH shifts res is the full result.
  always_comb begin
    d_bit    = opa[0] ^ opb[0] ^ br;
    br_next  = (~opa[0] & br) | (~opa[0] & opb[0]) | (opb[0] & br);
    res_ext  = {d_bit, res};
    res_next = res_ext[WIDTH:1];
    last     = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          opa <= opa >> 1;
          opb <= opb >> 1;
          br  <= br_next;
          res <= res_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff   <= res_next;
            borrow <= br_next;
            zero   <= (res_next == '0);
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: WIDTH=8 vectors, abort-by-reset, busy
// protection, and the WIDTH=1 full-subtractor truth table.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, borrow8, zero8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, borrow1, zero1;
  logic [0:0] diff1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .zero(zero1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; operands are scrambled after the start edge to show they are not re-sampled.
  task automatic go8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic binv,
                     input logic [7:0] ed, input logic eb, input logic ez);
    int k;
    logic [7:0] prev;
    logic hold_ok, busy_ok;
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~av; b8 = ~bv; bin8 = ~binv;
    prev = diff8; hold_ok = 1'b1; busy_ok = 1'b1; k = 1;
    while (done8 !== 1'b1 && k < 20) begin
      if (diff8 !== prev) hold_ok = 1'b0;
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 9);
    check({tag, "_hold"}, hold_ok, 1'b1);
    check({tag, "_busy"}, {busy_ok, busy8}, 2'b11);
    check({tag, "_diff"}, diff8, ed);
    check({tag, "_borrow"}, borrow8, eb);
    check({tag, "_zero"}, zero8, ez);
    @(negedge clk);
    check({tag, "_after"}, {done8, busy8}, 2'b00);
  endtask

  task automatic go1(input int idx, input logic ed, input logic eb);
    int k;
    @(negedge clk);
    {a1, b1, bin1} = 3'(idx); start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; k = 1;
    while (done1 !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("w1_%0d_latency", idx), k, 2);
    check($sformatf("w1_%0d_res", idx), {diff1, borrow1, zero1}, {ed, eb, ~ed});
  endtask

  initial begin
    int ndone, kd;
    logic [7:0] dv;
    logic busy_ok, nodone;
    logic [7:0] tt_d, tt_b;

    #12;
    check("rst_outputs8", {busy8, done8, diff8, borrow8, zero8}, 12'h0);
    check("rst_outputs1", {busy1, done1, diff1, borrow1, zero1}, 5'h0);
    @(negedge clk);
    rst = 1'b0;

    go8("sub_5_3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    go8("sub_3_5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    go8("sub_0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    go8("sub_eq",    8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1);
    go8("sub_ff_b",  8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);

    // Second start while busy must be ignored.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    ndone = 0; kd = 0; dv = '0; busy_ok = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (k == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1; end
      if (k == 4) start8 = 1'b0;
      if (done8 === 1'b1) begin ndone++; kd = k; dv = diff8; end
      if (k <= 9 && busy8 !== 1'b1) busy_ok = 1'b0;
    end
    check("busy_ignore_ndone", ndone, 1);
    check("busy_ignore_when", kd, 9);
    check("busy_ignore_diff", dv, 8'h02);
    check("busy_continuous", busy_ok, 1'b1);

    // Reset in mid-operation aborts without a done pulse.
    @(negedge clk);
    a8 = 8'h09; b8 = 8'h04; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_outputs", {busy8, done8, diff8, borrow8, zero8}, 12'h0);
    nodone = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) nodone = 1'b0;
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) nodone = 1'b0;
    end
    check("abort_no_done", nodone, 1'b1);
    go8("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // WIDTH=1 truth table indexed by {a,b,bin}.
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) go1(i, tt_d[i], tt_b[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
